// File: rtl/shift_unit_arbiter_pkg.sv
// Shared constants and encodings for the shift unit arbiter.
package shift_unit_arbiter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // Shift operation encodings carried on reqX_op.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  // One-entry response slot; rsp_valid is the FULL flag.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/shift_unit_arbiter_shifter.sv
// Logarithmic barrel shifter. dir=0 shifts left with zero fill,
// dir=1 shifts right filling vacated bits with feedinbit.
module shift_unit_arbiter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               feedinbit,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] stg [SHAMT_W+1];

  assign stg[0] = in;

  // Stage i shifts by 2**i when shamt[i] is set.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stg[i+1] = !shamt[i] ? stg[i] :
                      dir       ? {{S{feedinbit}}, stg[i][WIDTH-1:S]} :
                                  {stg[i][WIDTH-1-S:0], {S{1'b0}}};
  end

  assign out = stg[SHAMT_W];

endmodule

// File: rtl/shift_unit_arbiter.sv
// Two requesters share one barrel shifter through a round-robin arbiter;
// results come back through a one-entry registered response slot.
//
// Handshake: a request transfers on a rising edge where reqX_valid and
// reqX_ready are both high; a response transfers where rsp_valid and
// rsp_ready are both high. Requesters hold their payload stable while
// valid is high and ready is low; the response payload is held stable
// while rsp_valid is high and rsp_ready is low.
module shift_unit_arbiter #(
  parameter int WIDTH        = shift_unit_arbiter_pkg::WIDTH,
  parameter bit RR_RESET_PTR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [31:0]      req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  import shift_unit_arbiter_pkg::*;

  localparam int SW = $clog2(WIDTH);

  slot_e            state, state_nx;
  logic             ptr;
  logic             can_accept;
  logic             grant0, grant1, grant;
  logic [WIDTH-1:0] sel_a;
  logic [31:0]      sel_b;
  op_e              sel_op;
  logic             sat;
  logic             dir, fill;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result;

  assign can_accept = (state == SLOT_EMPTY) || rsp_ready;

  // Round-robin grant: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && can_accept) begin
      if (req0_valid && (!req1_valid || ptr == 1'b0))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign grant      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_a  = grant1 ? req1_a : req0_a;
  assign sel_b  = grant1 ? req1_b : req0_b;
  assign sel_op = op_e'(grant1 ? req1_op : req0_op);

  // Any amount of WIDTH or more saturates instead of wrapping.
  assign sat  = |sel_b[31:SW];
  assign dir  = (sel_op != OP_SLL);
  assign fill = (sel_op == OP_SRA) && sel_a[WIDTH-1];

  shift_unit_arbiter_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SW)
  ) u_shifter (
    .in        (sel_a),
    .shamt     (sel_b[SW-1:0]),
    .dir       (dir),
    .feedinbit (fill),
    .out       (shifted)
  );

  // Result select: illegal op yields zero, saturation yields all-fill.
  always_comb begin
    result = shifted;
    if (sel_op == OP_ILL)
      result = '0;
    else if (sat)
      result = {WIDTH{fill}};
  end

  // Slot next state: a grant always fills, a drain without grant empties.
  always_comb begin
    state_nx = state;
    if (grant)
      state_nx = SLOT_FULL;
    else if (state == SLOT_FULL && rsp_ready)
      state_nx = SLOT_EMPTY;
  end

  // Slot state, response payload and priority pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
      ptr      <= RR_RESET_PTR;
    end else begin
      state <= state_nx;
      if (grant) begin
        rsp_data <= result;
        rsp_id   <= grant1;
        rsp_err  <= (sel_op == OP_ILL);
        ptr      <= grant0;
      end
    end
  end

  assign rsp_valid = (state == SLOT_FULL);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with hand-computed expectations.
module tb_shift_unit_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  shift_unit_arbiter #(.WIDTH(32), .RR_RESET_PTR(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] data,
                         input logic id, input logic err);
    chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".data"},  rsp_data, data);
    chk({tag, ".id"},    {31'd0, rsp_id}, {31'd0, id});
    chk({tag, ".err"},   {31'd0, rsp_err}, {31'd0, err});
  endtask

  logic g;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b0, '0, '0, 2'b00);
    tick();
    tick();

    // Reset state, with requesters valid to prove readies are held low
    chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.data",  rsp_data, 32'd0);
    chk("rst.id",    {31'd0, rsp_id}, 32'd0);
    chk("rst.err",   {31'd0, rsp_err}, 32'd0);
    drive0(1'b1, 32'h1, 32'h1, 2'b00);
    drive1(1'b1, 32'h1, 32'h1, 2'b00);
    rsp_ready = 1'b1;
    settle();
    chk("rst.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b0, '0, '0, 2'b00);
    tick();
    rst = 1'b0;

    // Single request, 1-cycle latency
    drive0(1'b1, 32'h0000_00F0, 32'd4, 2'b00);
    settle();
    chk("single.ready", {30'd0, req1_ready, req0_ready}, 32'b01);
    tick();
    drive0(1'b0, '0, '0, 2'b00);
    chk_rsp("single", 32'h0000_0F00, 1'b0, 1'b0);
    tick();
    chk("drain.valid", {31'd0, rsp_valid}, 32'd0);

    // Saturation and right-shift boundaries on requester 1, back to back
    drive1(1'b1, 32'h8000_0001, 32'd40, 2'b10);
    settle();
    chk("sat.ready", {30'd0, req1_ready, req0_ready}, 32'b10);
    tick();
    chk_rsp("sra40", 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive1(1'b1, 32'h8000_0001, 32'd40, 2'b01);
    tick();
    chk_rsp("srl40", 32'h0000_0000, 1'b1, 1'b0);
    drive1(1'b1, 32'h8000_0001, 32'h1000_0001, 2'b00);
    tick();
    chk_rsp("sll_upper", 32'h0000_0000, 1'b1, 1'b0);
    drive1(1'b1, 32'h8000_0001, 32'd31, 2'b01);
    tick();
    chk_rsp("srl31", 32'h0000_0001, 1'b1, 1'b0);
    drive1(1'b1, 32'h8000_0001, 32'd31, 2'b10);
    tick();
    chk_rsp("sra31", 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive1(1'b1, 32'h8000_0001, 32'd4, 2'b10);
    tick();
    chk_rsp("sra4", 32'hF800_0000, 1'b1, 1'b0);
    drive1(1'b1, 32'h0000_0001, 32'd32, 2'b00);
    tick();
    chk_rsp("sll32", 32'h0000_0000, 1'b1, 1'b0);
    drive1(1'b0, '0, '0, 2'b00);

    // Illegal op and zero shift amount on requester 0
    drive0(1'b1, 32'h1234_5678, 32'd3, 2'b11);
    tick();
    chk_rsp("illegal", 32'h0000_0000, 1'b0, 1'b1);
    drive0(1'b1, 32'hDEAD_BEEF, 32'd0, 2'b01);
    tick();
    chk_rsp("shamt0", 32'hDEAD_BEEF, 1'b0, 1'b0);
    drive0(1'b0, '0, '0, 2'b00);
    tick();

    // Fresh reset, then fairness with both requesters always valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1'b1, 32'h0000_0001, 32'd1, 2'b00);
    drive1(1'b1, 32'h0000_0100, 32'd4, 2'b01);
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      settle();
      chk("rr.ready", {30'd0, req1_ready, req0_ready}, g ? 32'b10 : 32'b01);
      tick();
      chk_rsp("rr", g ? 32'h0000_0010 : 32'h0000_0002, g, 1'b0);
    end

    // Backpressure: slot full, consumer stalled, both requesters waiting
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      chk_rsp("bp.hold", 32'h0000_0010, 1'b1, 1'b0);
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp.release", {30'd0, req1_ready, req0_ready}, 32'b01);
    tick();
    chk_rsp("bp.next", 32'h0000_0002, 1'b0, 1'b0);

    // Reset while the slot is full and requester 1 is pending
    rsp_ready = 1'b0;
    drive0(1'b0, '0, '0, 2'b00);
    rst = 1'b1;
    settle();
    chk("midrst.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    chk("midrst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst.data",  rsp_data, 32'd0);
    chk("midrst.ready2", {30'd0, req1_ready, req0_ready}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    drive0(1'b1, 32'h0000_0001, 32'd1, 2'b00);
    settle();
    chk("midrst.ptr", {30'd0, req1_ready, req0_ready}, 32'b01);
    tick();
    chk_rsp("midrst.first", 32'h0000_0002, 1'b0, 1'b0);
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b0, '0, '0, 2'b00);
    tick();
    chk("final.drain", {31'd0, rsp_valid}, 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
